// File: rtl/ifu_fetch_pkg.sv
// ifu_fetch_pkg: shared FSM state type and constants for the instruction
// fetch unit and its output holding register.
package ifu_fetch_pkg;

  typedef enum logic [1:0] {
    IFU_IDLE = 2'd0,
    IFU_REQ  = 2'd1,
    IFU_WAIT = 2'd2,
    IFU_OUT  = 2'd3
  } ifu_state_t;

  localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;
  localparam logic [31:0] NOP          = 32'h0000_0013;
  localparam logic [31:0] INST_BYTES   = 32'd4;

  // Instruction fetches are always word aligned; low address bits are dropped.
  function automatic logic [31:0] alignPc(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/ifu_fetch_out_reg.sv
// ifu_out_reg: holding register for the instruction presented to decode.
// Keeps inst/pc/snpc stable while decode stalls, and drops the valid flag
// when decode accepts or when the front end is flushed.
module ifu_out_reg
  import ifu_fetch_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        load_i,
  input  logic        clear_i,
  input  logic        accept_i,
  input  logic [31:0] inst_i,
  input  logic [31:0] pc_i,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o,
  output logic [31:0] snpc_o,
  output logic        valid_o
);

  logic [31:0] inst_q;
  logic [31:0] pc_q;
  logic [31:0] snpc_q;
  logic        valid_q;

  // A flush beats a fresh load, which beats a plain hand-off; pc/snpc are kept
  // on a flush so a later fence.i can still refer to the last held instruction.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      inst_q  <= 32'd0;
      pc_q    <= 32'd0;
      snpc_q  <= INST_BYTES;
      valid_q <= 1'b0;
    end else if (clear_i) begin
      inst_q  <= NOP;
      valid_q <= 1'b0;
    end else if (load_i) begin
      inst_q  <= inst_i;
      pc_q    <= pc_i;
      snpc_q  <= pc_i + INST_BYTES;
      valid_q <= 1'b1;
    end else if (accept_i) begin
      valid_q <= 1'b0;
    end
  end

  assign inst_o  = inst_q;
  assign pc_o    = pc_q;
  assign snpc_o  = snpc_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch unit, producer side of the fetch->decode
// handshake. Holds the fetch PC, keeps at most one imem read in flight and
// applies redirects. Optional fence.i refetch and icache invalidate pulse are
// enabled by defining IFU_FENCE_I_EN; otherwise fence_i_flag is ignored.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = IFU_RESET_PC
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        fence_i_flag,
  output logic        icache_inv,
  output logic [31:0] inst,
  output logic [31:0] pc,
  output logic [31:0] snpc,
  output logic        valid_next,
  input  logic        ready_next
);

  ifu_state_t  state_q;
  logic [31:0] fetchPc_q;
  logic        kill_q;
  logic        imemReq_q;
  logic [31:0] imemAddr_q;
  logic        icacheInv_q;

  logic [31:0] redirectTarget;
  logic [31:0] restartPc;
  logic [31:0] refetchPc;
  logic [31:0] advancePc;
  logic        fenceHit;
  logic        flush;
  logic        loadOut;
  logic        acceptOut;

`ifdef IFU_FENCE_I_EN
  assign fenceHit = fence_i_flag & ~redirect_valid;
`else
  logic unusedFenceFlag;
  assign unusedFenceFlag = fence_i_flag;
  assign fenceHit        = 1'b0;
`endif

  assign redirectTarget = alignPc(redirect_pc);
  assign flush          = redirect_valid | fenceHit;
  assign restartPc      = redirect_valid ? redirectTarget : snpc;
  assign refetchPc      = redirect_valid ? redirectTarget : fetchPc_q;
  assign advancePc      = redirect_valid ? redirectTarget : snpc;
  assign loadOut        = (state_q == IFU_WAIT) & imem_rvalid & ~kill_q & ~flush;
  assign acceptOut      = (state_q == IFU_OUT) & ready_next;

  // Fetch FSM: owns the fetch PC, the kill flag for an abandoned in-flight read,
  // and the registered imem request/address and invalidate pulse.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IFU_IDLE;
      fetchPc_q   <= RESET_PC;
      kill_q      <= 1'b0;
      imemReq_q   <= 1'b0;
      imemAddr_q  <= 32'd0;
      icacheInv_q <= 1'b0;
    end else begin
      icacheInv_q <= fenceHit;
      unique case (state_q)
        IFU_IDLE: begin
          if (fenceHit) begin
            fetchPc_q <= snpc;
          end else begin
            state_q    <= IFU_REQ;
            imemReq_q  <= 1'b1;
            fetchPc_q  <= refetchPc;
            imemAddr_q <= refetchPc;
          end
        end
        IFU_REQ: begin
          if (imem_gnt) begin
            imemReq_q <= 1'b0;
            state_q   <= IFU_WAIT;
            if (flush) begin
              kill_q    <= 1'b1;
              fetchPc_q <= restartPc;
            end
          end else if (redirect_valid) begin
            fetchPc_q  <= redirectTarget;
            imemAddr_q <= redirectTarget;
          end else if (fenceHit) begin
            fetchPc_q <= snpc;
            imemReq_q <= 1'b0;
            state_q   <= IFU_IDLE;
          end
        end
        IFU_WAIT: begin
          if (imem_rvalid) begin
            kill_q <= 1'b0;
            if (fenceHit) begin
              fetchPc_q <= snpc;
              state_q   <= IFU_IDLE;
            end else if (redirect_valid || kill_q) begin
              state_q    <= IFU_REQ;
              imemReq_q  <= 1'b1;
              fetchPc_q  <= refetchPc;
              imemAddr_q <= refetchPc;
            end else begin
              state_q <= IFU_OUT;
            end
          end else if (flush) begin
            kill_q    <= 1'b1;
            fetchPc_q <= restartPc;
          end
        end
        IFU_OUT: begin
          if (fenceHit) begin
            fetchPc_q <= snpc;
            state_q   <= IFU_IDLE;
          end else if (redirect_valid || ready_next) begin
            state_q    <= IFU_REQ;
            imemReq_q  <= 1'b1;
            fetchPc_q  <= advancePc;
            imemAddr_q <= advancePc;
          end
        end
        default: state_q <= IFU_IDLE;
      endcase
    end
  end

  ifu_out_reg uOutReg (
    .clock    (clock),
    .reset    (reset),
    .load_i   (loadOut),
    .clear_i  (flush),
    .accept_i (acceptOut),
    .inst_i   (imem_rdata),
    .pc_i     (fetchPc_q),
    .inst_o   (inst),
    .pc_o     (pc),
    .snpc_o   (snpc),
    .valid_o  (valid_next)
  );

  assign imem_req   = imemReq_q;
  assign imem_addr  = imemAddr_q;
  assign icache_inv = icacheInv_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: directed bench for ifu_fetch with a single-outstanding memory
// responder and a transaction-level model of which PC must be fetched/presented.
module tb_ifu_fetch;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fence_i_flag;
  logic        icache_inv;
  logic [31:0] inst;
  logic [31:0] pc;
  logic [31:0] snpc;
  logic        valid_next;
  logic        ready_next;

  int testCount = 0;
  int failCount = 0;
  int memLat    = 1;

  ifu_fetch #(.RESET_PC(RESET_PC)) dut (
    .clock          (clock),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fence_i_flag   (fence_i_flag),
    .icache_inv     (icache_inv),
    .inst           (inst),
    .pc             (pc),
    .snpc           (snpc),
    .valid_next     (valid_next),
    .ready_next     (ready_next)
  );

  // 10 ns clock period
  always #5 clock = ~clock;

  // Memory content: an addi whose immediate is the word index, so every word differs
  function automatic logic [31:0] memWord(input logic [31:0] a);
    memWord = {a[13:2], 20'h00093};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic rv, input logic [31:0] rpc, input logic rdy, input logic fence);
    redirect_valid = rv;
    redirect_pc    = rpc;
    ready_next     = rdy;
    fence_i_flag   = fence;
  endtask

  task automatic waitValid();
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!valid_next && n < 40);
    testCount++;
    if (!valid_next) begin
      failCount++;
      $display("[TB] FAIL waitValid: actual=timeout required=valid_next within 40 cycles");
    end
  endtask

  task automatic waitReq();
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!imem_req && n < 40);
    testCount++;
    if (!imem_req) begin
      failCount++;
      $display("[TB] FAIL waitReq: actual=timeout required=imem_req within 40 cycles");
    end
  endtask

  // Memory responder: grants immediately when idle, answers memLat cycles later,
  // keeps only one read outstanding and ignores reset (stale data can arrive late)
  initial begin
    int pendCnt;
    logic [31:0] pendAddr;
    pendCnt     = 0;
    pendAddr    = 32'd0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'd0;
    forever begin
      @(negedge clock);
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b0;
      if (pendCnt > 0) begin
        pendCnt--;
        if (pendCnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = memWord(pendAddr);
        end
      end else if (imem_req) begin
        imem_gnt = 1'b1;
        pendAddr = imem_addr;
        pendCnt  = memLat;
      end
    end
  end

  // Reference model: tracks the PC that must be fetched next and the PC of the
  // instruction last handed to decode; checks outputs once per cycle
  initial begin
    logic [31:0] modelPc;
    logic [31:0] heldPc;
    logic        expInv;
    logic        holdExp;
    logic        dropExp;
    logic        fenceEff;
    modelPc = RESET_PC;
    heldPc  = 32'd0;
    expInv  = 1'b0;
    holdExp = 1'b0;
    dropExp = 1'b0;
    forever begin
      @(negedge clock);
      #1;
      if (!reset) begin
        checkOutput("rstReq", imem_req, 0);
        checkOutput("rstAddr", imem_addr, 0);
        checkOutput("rstInst", inst, 0);
        checkOutput("rstPc", pc, 0);
        checkOutput("rstSnpc", snpc, 4);
        checkOutput("rstValid", valid_next, 0);
        checkOutput("rstInv", icache_inv, 0);
        modelPc = RESET_PC;
        heldPc  = 32'd0;
        expInv  = 1'b0;
        holdExp = 1'b0;
        dropExp = 1'b0;
      end else begin
`ifdef IFU_FENCE_I_EN
        checkOutput("icacheInv", icache_inv, expInv);
        fenceEff = fence_i_flag && !redirect_valid;
`else
        checkOutput("icacheInvTied", icache_inv, 0);
        fenceEff = 1'b0;
`endif
        if (valid_next) begin
          checkOutput("modelPc", pc, modelPc);
          checkOutput("modelInst", inst, memWord(modelPc));
          checkOutput("modelSnpc", snpc, modelPc + 32'd4);
          checkOutput("noReqInOut", imem_req, 0);
        end
        if (holdExp) checkOutput("holdValid", valid_next, 1);
        if (dropExp) checkOutput("dropAfterFlush", valid_next, 0);
        if (imem_req) checkOutput("reqAddr", imem_addr, modelPc);
        holdExp = valid_next && !ready_next && !redirect_valid && !fenceEff;
        dropExp = valid_next && (redirect_valid || fenceEff);
        expInv  = fenceEff;
        if (valid_next) heldPc = modelPc;
        if (redirect_valid) modelPc = redirect_pc & ~32'h3;
        else if (fenceEff) modelPc = heldPc + 32'd4;
        else if (valid_next && ready_next) modelPc = modelPc + 32'd4;
      end
    end
  end

  // Watchdog so the run always ends
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: actual=no finish required=finish before 100us");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios with hand-computed expectations
  initial begin
    logic sawValid;
    int   n;
    applyStimulus(0, 32'd0, 1, 0);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    checkOutput("resetSnpcLit", snpc, 32'h0000_0004);

    // Reset release: IDLE, REQ, WAIT, OUT at cycles 1..4
    @(negedge clock);
    reset = 1'b1;
    #1;
    checkOutput("c1Req", imem_req, 0);
    @(negedge clock);
    checkOutput("c2Req", imem_req, 1);
    checkOutput("c2Addr", imem_addr, 32'h8000_0000);
    @(negedge clock);
    checkOutput("c3Valid", valid_next, 0);
    @(negedge clock);
    checkOutput("c4Valid", valid_next, 1);
    checkOutput("c4Pc", pc, 32'h8000_0000);
    checkOutput("c4Snpc", snpc, 32'h8000_0004);
    checkOutput("c4Inst", inst, 32'h0000_0093);
    @(negedge clock);
    checkOutput("c5Req", imem_req, 1);
    checkOutput("c5Addr", imem_addr, 32'h8000_0004);

    // Decode stall for 5 cycles
    waitValid();
    applyStimulus(0, 32'd0, 0, 0);
    checkOutput("stallPc0", pc, 32'h8000_0004);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      checkOutput("stallValid", valid_next, 1);
      checkOutput("stallPc", pc, 32'h8000_0004);
      checkOutput("stallInst", inst, 32'h0010_0093);
      checkOutput("stallNoReq", imem_req, 0);
    end
    applyStimulus(0, 32'd0, 1, 0);

    // Redirect during WAIT with a 3-cycle memory
    memLat = 3;
    waitReq();
    @(negedge clock);
    checkOutput("t3InWait", imem_req, 0);
    applyStimulus(1, 32'h8000_0100, 1, 0);
    @(negedge clock);
    applyStimulus(0, 32'd0, 1, 0);
    sawValid = 1'b0;
    n = 0;
    while (!imem_req && n < 12) begin
      if (valid_next) sawValid = 1'b1;
      @(negedge clock);
      n++;
    end
    checkOutput("t3StaleDropped", sawValid, 0);
    checkOutput("t3ReqSeen", imem_req, 1);
    checkOutput("t3Addr", imem_addr, 32'h8000_0100);
    waitValid();
    checkOutput("t3Pc", pc, 32'h8000_0100);
    checkOutput("t3Inst", inst, 32'h0400_0093);

    // Redirect in the same cycle as rvalid
    waitReq();
    repeat (3) @(negedge clock);
    applyStimulus(1, 32'h8000_0203, 1, 0);
    @(negedge clock);
    applyStimulus(0, 32'd0, 1, 0);
    checkOutput("t4Req", imem_req, 1);
    checkOutput("t4Addr", imem_addr, 32'h8000_0200);
    checkOutput("t4NoValid", valid_next, 0);
    waitValid();
    checkOutput("t4Pc", pc, 32'h8000_0200);
    checkOutput("t4Inst", inst, 32'h0800_0093);

    // snpc wraps at the top of the address space
    memLat = 1;
    applyStimulus(1, 32'hFFFF_FFFC, 1, 0);
    @(negedge clock);
    applyStimulus(0, 32'd0, 1, 0);
    waitValid();
    checkOutput("wrapPc", pc, 32'hFFFF_FFFC);
    checkOutput("wrapSnpc", snpc, 32'h0000_0000);

    // fence.i while presenting pc 0x8000_0010
    applyStimulus(1, 32'h8000_0010, 0, 0);
    @(negedge clock);
    applyStimulus(0, 32'd0, 0, 0);
    waitValid();
    checkOutput("fencePc", pc, 32'h8000_0010);
    applyStimulus(0, 32'd0, 0, 1);
    @(negedge clock);
    applyStimulus(0, 32'd0, 0, 0);
`ifdef IFU_FENCE_I_EN
    checkOutput("fenceInvPulse", icache_inv, 1);
    checkOutput("fenceValidDrop", valid_next, 0);
    checkOutput("fenceNoReq", imem_req, 0);
    @(negedge clock);
    checkOutput("fenceInvEnd", icache_inv, 0);
    checkOutput("fenceReq", imem_req, 1);
    checkOutput("fenceAddr", imem_addr, 32'h8000_0014);
`else
    checkOutput("fenceIgnoredInv", icache_inv, 0);
    checkOutput("fenceIgnoredValid", valid_next, 1);
    checkOutput("fenceIgnoredPc", pc, 32'h8000_0010);
`endif
    applyStimulus(0, 32'd0, 1, 0);

    // Reset asserted during WAIT; the late response must be ignored
    memLat = 3;
    waitReq();
    @(negedge clock);
    reset = 1'b0;
    #1;
    checkOutput("midRstReq", imem_req, 0);
    checkOutput("midRstValid", valid_next, 0);
    checkOutput("midRstPc", pc, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    waitValid();
    checkOutput("postRstPc", pc, 32'h8000_0000);
    checkOutput("postRstInst", inst, 32'h0000_0093);

    repeat (3) @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/ifu_fetch.md
# ifu_fetch

Instruction fetch unit for the three-stage RV32I core: the producer side of the fetch→decode valid/ready handshake. It holds the architectural PC, issues one instruction-memory read at a time, and presents `inst`/`pc`/`snpc` to the decode stage. It also applies redirects from branch/jump/trap/mret resolution and, optionally, `fence.i` refetch.

## Interface
- `RESET_PC`, default 32'h8000_0000: first fetch address after reset.
- `clock` in 1: single clock; all state on rising edge.
- `reset` in 1: asynchronous, active-low.
- `imem_req` out 1: read request.
- `imem_addr` out 32: word-aligned fetch address.
- `imem_gnt` in 1: request accepted this cycle.
- `imem_rvalid` in 1: read data valid; at least 1 cycle after the granting cycle.
- `imem_rdata` in 32: instruction word.
- `redirect_valid` in 1: taken branch, jump, ecall or mret resolved.
- `redirect_pc` in 32: target address; bits [1:0] are forced to 0.
- `fence_i_flag` in 1: `fence.i` retired (used only with `IFU_FENCE_I_EN`).
- `icache_inv` out 1: one-cycle invalidate pulse.
- `inst` out 32: fetched instruction.
- `pc` out 32: address of `inst`.
- `snpc` out 32: `pc + 4`, modulo 2^32.
- `valid_next` out 1: `inst`/`pc`/`snpc` valid to decode.
- `ready_next` in 1: decode accepts.

## Operation
- FSM states: IDLE, REQ, WAIT, OUT.
- IDLE is occupied for one cycle after reset release, then goes to REQ.
- REQ
  - `imem_req`=1, `imem_addr`=`fetch_pc`.
  - On `imem_gnt` → WAIT.
- WAIT
  - On `imem_rvalid`: capture `imem_rdata` into `inst` and `fetch_pc` into `pc` → OUT.
  - If the kill flag is set, the response is dropped instead → REQ.
- OUT
  - `valid_next`=1.
  - On `ready_next`: `fetch_pc` ← `pc+4` → REQ.
  - `inst`, `pc` and `snpc` stay stable while `valid_next`=1 and `ready_next`=0.
- Redirect (`redirect_valid`=1) handling by state:
  - IDLE or REQ: `fetch_pc` ← target, state stays REQ. An ungranted request carries no commitment, so the address may change.
  - WAIT: `fetch_pc` ← target, kill flag set. The in-flight response is discarded on arrival and the kill flag is cleared.
  - OUT: `valid_next` drops next cycle, `fetch_pc` ← target → REQ. This applies even if `ready_next`=1 in the same cycle; redirect wins.
- Redirect and `imem_rvalid` in the same WAIT cycle: the data is discarded → REQ with the target.
- Redirect has priority over `fence_i_flag`.
- Only one request is outstanding at any time. `imem_req` is never asserted in WAIT or OUT.

## Timing
- Reset values: `imem_req`=0, `imem_addr`=0, `inst`=0, `pc`=0, `snpc`=4, `valid_next`=0, `icache_inv`=0, `fetch_pc`=`RESET_PC`, kill flag=0, state=IDLE.
- Reset asserted mid-operation: immediate return to reset values. Any later `imem_rvalid` belonging to the aborted request is ignored, because it arrives in IDLE or REQ.
- Latency from reset release:
  - Cycle 1 is IDLE.
  - Cycle 2 raises `imem_req`.
  - With immediate grant and 1-cycle `rvalid`, `valid_next` rises in cycle 4.
- Steady throughput with immediate grant, 1-cycle memory and decode always ready: one instruction per 3 cycles (REQ, WAIT, OUT).
- Redirect in cycle N: the request for the target is issued in cycle N+1 at the earliest.
- `snpc` wraps: `pc`=32'hFFFF_FFFC gives `snpc`=0.

## Configuration
- `IFU_FENCE_I_EN` defined:
  - `fence_i_flag` in any state: `icache_inv`=1 for exactly one cycle (the next cycle).
  - `fetch_pc` ← `pc+4` of the instruction currently held, with kill semantics identical to a redirect.
  - Fetch restarts after the pulse.
- `IFU_FENCE_I_EN` undefined: `fence_i_flag` is ignored and `icache_inv` is tied 0.

## Structure
- Shared package (`para.sv` macros / core package):
  - FSM state enum `ifu_state_t`.
  - `RESET_PC` default constant.
  - `NOP` encoding 32'h0000_0013.
- Natural sub-module: `ifu_out_reg`, the output holding register for `inst`/`pc`/`snpc`/`valid_next` with hold-on-stall and clear-on-redirect. The FSM, `fetch_pc` and the kill flag stay in `ifu_fetch`.

## Test plan
- Reset release, memory grants immediately and returns 32'h0000_0093 after 1 cycle, decode always ready:
  - first `imem_addr`=32'h8000_0000;
  - `valid_next` in cycle 4 with `pc`=32'h8000_0000, `snpc`=32'h8000_0004;
  - next request to 32'h8000_0004.
- Decode stall: `ready_next`=0 for 5 cycles → `valid_next`, `inst` and `pc` are held constant, and no `imem_req` is issued.
- Redirect to 32'h8000_0100 during WAIT with a 3-cycle memory:
  - the stale response is dropped and `valid_next` never presents it;
  - the next `imem_addr` is 32'h8000_0100.
- Redirect to 32'h8000_0203 in the same cycle as `imem_rvalid` → data is discarded; the next request is to 32'h8000_0200.
- `IFU_FENCE_I_EN` defined, `fence_i_flag` while OUT with `pc`=32'h8000_0010 → `icache_inv` pulses for 1 cycle, then a refetch from 32'h8000_0014.
- `reset` asserted while in WAIT, with `rvalid` arriving after release → response ignored; the fetch restarts at `RESET_PC`.
